memory_inhibit_driver: RTL and testbench

Write-side counterpart of the buffer register: takes a buffer-register word and restores it into core memory. On a write request it latches the 13 data bits, generates the parity bit, and sequences the inhibit drivers and X/Y write currents for the selected memory module or duplex pair. Sits between the buffer register outputs (BRx1..BRx13) and the memory module drive lines (Ma..Md), mirroring the sense-amplifier load path.

---
 rtl/lvdc_mem_pkg.sv | 36 +++
 rtl/inhibit_phase_counter.sv | 33 +++
 rtl/memory_inhibit_driver.sv | 175 +++++++++++++++++
 tb/tb_memory_inhibit_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lvdc_mem_pkg.sv
// Shared definitions for the LVDC core-memory write path.
//   - Write sequencer state encoding (IDLE/SETUP/WRITE/RECOV)
//   - Module-select mask constants for Ma..Md and the two duplex pairs
//   - mod_sel_legal(): accepts one-hot masks and the two duplex pairs only
package lvdc_mem_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 13;
    localparam int unsigned MOD_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_RECOV = 2'd3
    } wrState_e;

    localparam logic [MOD_W-1:0] MOD_A     = 4'b0001;
    localparam logic [MOD_W-1:0] MOD_B     = 4'b0010;
    localparam logic [MOD_W-1:0] MOD_C     = 4'b0100;
    localparam logic [MOD_W-1:0] MOD_D     = 4'b1000;
    localparam logic [MOD_W-1:0] DUPLEX_AB = 4'b0011;
    localparam logic [MOD_W-1:0] DUPLEX_CD = 4'b1100;

    // Any single module, or one of the two hard-wired duplex pairs.
    function automatic logic mod_sel_legal(input logic [MOD_W-1:0] mask);
        logic legal;
        case (mask)
            MOD_A, MOD_B, MOD_C, MOD_D,
            DUPLEX_AB, DUPLEX_CD: legal = 1'b1;
            default:              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/inhibit_phase_counter.sv
// Loadable down-counter timing each phase of the inhibit/write sequence.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (count -> 0)
//   load       - load loadValue this cycle (has priority over dec)
//   loadValue  - value to load
//   dec        - decrement by one; holds at zero
//   count      - current count
//   zero       - count == 0
module inhibit_phase_counter
    import lvdc_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_inhibit_driver.sv
// Write-side restore path: latches a buffer-register word, generates its
// parity bit and sequences inhibit drivers and X/Y write currents for the
// selected core-memory module (or duplex pair).
// Parameters:
//   T_SETUP - cycles inhibit settles before write current (1..15)
//   T_WRITE - cycles X/Y write current is held             (1..15)
//   T_RECOV - cycles all drives are off before next accept (1..15)
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   wr_req   - write request, sampled only while idle
//   mod_sel  - module select (bit0=Ma .. bit3=Md); one-hot or 0011/1100
//   br_data  - BRx13..BRx1 (bit0 = BRx1)
//   wr_ack   - one-cycle pulse, request accepted
//   busy     - high from acceptance through the end of recovery
//   done     - one-cycle pulse as the sequencer returns to idle
//   err      - one-cycle pulse, request rejected for an illegal mod_sel
//   inh      - inhibit drive per bit, bit13 = parity; high writes a 0
//   xy_wr    - X/Y write-current enable per module
//   mod_act  - latched module mask
module memory_inhibit_driver
    import lvdc_mem_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_WRITE = 4,
    parameter int unsigned T_RECOV = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [MOD_W-1:0]  mod_sel,
    input  logic [DATA_W-1:0] br_data,
    output logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W:0]   inh,
    output logic [MOD_W-1:0]  xy_wr,
    output logic [MOD_W-1:0]  mod_act
);

    if ((T_SETUP < 1) || (T_SETUP > 15)) begin : gBadSetup
        $error("memory_inhibit_driver: T_SETUP must be in 1..15");
    end
    if ((T_WRITE < 1) || (T_WRITE > 15)) begin : gBadWrite
        $error("memory_inhibit_driver: T_WRITE must be in 1..15");
    end
    if ((T_RECOV < 1) || (T_RECOV > 15)) begin : gBadRecov
        $error("memory_inhibit_driver: T_RECOV must be in 1..15");
    end

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(T_WRITE - 1);
    localparam logic [CNT_W-1:0] RECOV_LOAD = CNT_W'(T_RECOV - 1);

    wrState_e          state;
    wrState_e          nextState;
    logic [DATA_W-1:0] dataQ;
    logic              parQ;

    logic              isIdle;
    logic              accept;
    logic              reject;

    logic              cntLoad;
    logic [CNT_W-1:0]  cntLoadValue;
    logic              cntDec;
    logic [CNT_W-1:0]  cntValue;
    logic              cntZero;

    logic [DATA_W-1:0] dataNext;
    logic              parNext;
    logic [DATA_W:0]   inhPattern;
    logic              driveInh;
    logic              driveXy;

    assign isIdle = (state == ST_IDLE);
    assign accept = isIdle && wr_req && mod_sel_legal(mod_sel);
    assign reject = isIdle && wr_req && !mod_sel_legal(mod_sel);

    inhibit_phase_counter uPhaseCounter (
        .clk       (clk),
        .rst       (rst),
        .load      (cntLoad),
        .loadValue (cntLoadValue),
        .dec       (cntDec),
        .count     (cntValue),
        .zero      (cntZero)
    );

    // Phase sequencing: each phase lasts (load value + 1) cycles.
    always_comb begin
        nextState    = state;
        cntLoad      = 1'b0;
        cntLoadValue = '0;
        cntDec       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nextState    = ST_SETUP;
                    cntLoad      = 1'b1;
                    cntLoadValue = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cntZero) begin
                    nextState    = ST_WRITE;
                    cntLoad      = 1'b1;
                    cntLoadValue = WRITE_LOAD;
                end else begin
                    cntDec = 1'b1;
                end
            end
            ST_WRITE: begin
                if (cntZero) begin
                    nextState    = ST_RECOV;
                    cntLoad      = 1'b1;
                    cntLoadValue = RECOV_LOAD;
                end else begin
                    cntDec = 1'b1;
                end
            end
            ST_RECOV: begin
                if (cntZero) begin
                    nextState = ST_IDLE;
                end else begin
                    cntDec = 1'b1;
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // Drive outputs are registered from the next-state view so that they
    // switch on the same edge as the state they belong to, without any
    // combinational path from the inputs.
    always_comb begin
        dataNext   = accept ? br_data : dataQ;
        parNext    = accept ? ~^br_data : parQ;
        inhPattern = ~{parNext, dataNext};
        driveInh   = (nextState == ST_SETUP) || (nextState == ST_WRITE);
        driveXy    = (nextState == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            dataQ   <= '0;
            parQ    <= 1'b0;
            mod_act <= '0;
            inh     <= '0;
            xy_wr   <= '0;
            wr_ack  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state  <= nextState;
            dataQ  <= dataNext;
            parQ   <= parNext;
            if (accept) begin
                mod_act <= mod_sel;
            end
            inh    <= driveInh ? inhPattern : '0;
            // mod_act cannot change outside IDLE, so it is safe to use here.
            xy_wr  <= driveXy ? mod_act : '0;
            wr_ack <= accept;
            err    <= reject;
            busy   <= (nextState != ST_IDLE);
            done   <= (state == ST_RECOV) && cntZero;
        end
    end

endmodule

// File: tb/tb_memory_inhibit_driver.sv
module tb_memory_inhibit_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [3:0]  mod_sel;
    logic [12:0] br_data;

    logic        wrAck   [2];
    logic        busyO   [2];
    logic        doneO   [2];
    logic        errO    [2];
    logic [13:0] inhO    [2];
    logic [3:0]  xyO     [2];
    logic [3:0]  modActO [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_inhibit_driver #(.T_SETUP(2), .T_WRITE(4), .T_RECOV(3)) dutDef (
        .clk(clk), .rst(rst), .wr_req(wr_req), .mod_sel(mod_sel), .br_data(br_data),
        .wr_ack(wrAck[0]), .busy(busyO[0]), .done(doneO[0]), .err(errO[0]),
        .inh(inhO[0]), .xy_wr(xyO[0]), .mod_act(modActO[0])
    );

    memory_inhibit_driver #(.T_SETUP(1), .T_WRITE(1), .T_RECOV(1)) dutFast (
        .clk(clk), .rst(rst), .wr_req(wr_req), .mod_sel(mod_sel), .br_data(br_data),
        .wr_ack(wrAck[1]), .busy(busyO[1]), .done(doneO[1]), .err(errO[1]),
        .inh(inhO[1]), .xy_wr(xyO[1]), .mod_act(modActO[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int unsigned tS [2] = '{2, 1};
    int unsigned tW [2] = '{4, 1};
    int unsigned tR [2] = '{3, 1};

    bit          cmpEn = 1'b0;
    int          cyc   = 0;
    bit          mActive [2];
    int          mAcc    [2];
    logic [12:0] mData   [2];
    logic [3:0]  mMask   [2];
    logic [3:0]  mModAct [2];
    bit          mErr    [2];

    function automatic bit legalMask(input logic [3:0] m);
        return (m == 4'b0011) || (m == 4'b1100) || ($countones(m) == 1);
    endfunction

    always @(posedge clk) begin
        int total;
        int k;
        bit idle;
        bit act;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            total   = int'(tS[i] + tW[i] + tR[i]);
            idle    = !mActive[i] || ((cyc - 1 - mAcc[i]) >= total);
            mErr[i] = 1'b0;
            if (rst) begin
                mActive[i] = 1'b0;
                mModAct[i] = 4'b0000;
            end else if (idle && wr_req) begin
                if (legalMask(mod_sel)) begin
                    mActive[i] = 1'b1;
                    mAcc[i]    = cyc;
                    mData[i]   = br_data;
                    mMask[i]   = mod_sel;
                    mModAct[i] = mod_sel;
                end else begin
                    mErr[i] = 1'b1;
                end
            end
        end
        #1;
        if (cmpEn) begin
            for (int i = 0; i < 2; i++) begin
                total = int'(tS[i] + tW[i] + tR[i]);
                k     = cyc - mAcc[i];
                act   = mActive[i];
                chk($sformatf("wr_ack[%0d] cyc%0d", i, cyc), 32'(wrAck[i]), 32'(act && k == 0));
                chk($sformatf("busy[%0d] cyc%0d", i, cyc), 32'(busyO[i]), 32'(act && k < total));
                chk($sformatf("done[%0d] cyc%0d", i, cyc), 32'(doneO[i]), 32'(act && k == total));
                chk($sformatf("err[%0d] cyc%0d", i, cyc), 32'(errO[i]), 32'(mErr[i]));
                chk($sformatf("inh[%0d] cyc%0d", i, cyc), 32'(inhO[i]),
                    (act && k < int'(tS[i] + tW[i])) ? 32'({^mData[i], ~mData[i]}) : 32'h0);
                chk($sformatf("xy_wr[%0d] cyc%0d", i, cyc), 32'(xyO[i]),
                    (act && k >= int'(tS[i]) && k < int'(tS[i] + tW[i])) ? 32'(mMask[i]) : 32'h0);
                chk($sformatf("mod_act[%0d] cyc%0d", i, cyc), 32'(modActO[i]), 32'(mModAct[i]));
            end
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    logic [3:0] legalList [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};
    logic [3:0] badList   [3] = '{4'b0000, 4'b0101, 4'b0111};

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int acks0;
        int acks1;
        int xyCount;

        rst = 1'b1; wr_req = 1'b0; mod_sel = 4'b0000; br_data = '0;
        @(negedge clk);
        @(negedge clk);
        cmpEn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset busy", 32'(busyO[0]), 32'h0);
        chk("reset inh", 32'(inhO[0]), 32'h0);
        chk("reset mod_act", 32'(modActO[0]), 32'h0);
        idleCycles(1);

        // Single write to Ma, 1555 -> inh 2AAA
        br_data = 13'h1555; mod_sel = 4'b0001; wr_req = 1'b1;
        @(posedge clk); #2;
        chk("t1 ack +1", 32'(wrAck[0]), 32'h1);
        chk("t1 inh +1", 32'(inhO[0]), 32'h2AAA);
        chk("t1 fast ack +1", 32'(wrAck[1]), 32'h1);
        @(negedge clk);
        wr_req = 1'b0;
        for (int m = 2; m <= 10; m++) begin
            @(posedge clk); #2;
            chk($sformatf("t1 inh +%0d", m), 32'(inhO[0]), (m <= 6) ? 32'h2AAA : 32'h0);
            chk($sformatf("t1 xy +%0d", m), 32'(xyO[0]), (m >= 3 && m <= 6) ? 32'h1 : 32'h0);
            chk($sformatf("t1 done +%0d", m), 32'(doneO[0]), (m == 10) ? 32'h1 : 32'h0);
            chk($sformatf("t1 fast xy +%0d", m), 32'(xyO[1]), (m == 2) ? 32'h1 : 32'h0);
            chk($sformatf("t1 fast done +%0d", m), 32'(doneO[1]), (m == 4) ? 32'h1 : 32'h0);
        end
        idleCycles(2);

        // Duplex C/D, all ones -> inh 2000, xy 1100 for 4 cycles
        br_data = 13'h1FFF; mod_sel = 4'b1100; wr_req = 1'b1;
        @(posedge clk); #2;
        chk("t2 inh", 32'(inhO[0]), 32'h2000);
        @(negedge clk);
        wr_req = 1'b0; mod_sel = 4'b0001; br_data = 13'h0000;
        xyCount = 0;
        for (int m = 2; m <= 12; m++) begin
            @(posedge clk); #2;
            if (xyO[0] == 4'b1100) xyCount++;
        end
        chk("t2 xy cycles", 32'(xyCount), 32'd4);
        idleCycles(1);

        // Illegal masks
        for (int b = 0; b < 3; b++) begin
            mod_sel = badList[b]; wr_req = 1'b1;
            @(posedge clk); #2;
            chk($sformatf("bad%0d err", b), 32'(errO[0]), 32'h1);
            chk($sformatf("bad%0d busy", b), 32'(busyO[0]), 32'h0);
            chk($sformatf("bad%0d xy", b), 32'(xyO[0]), 32'h0);
            @(negedge clk);
            wr_req = 1'b0;
            @(posedge clk); #2;
            chk($sformatf("bad%0d err clr", b), 32'(errO[0]), 32'h0);
            @(negedge clk);
        end
        idleCycles(2);

        // Held request: one acceptance per 1+T_SETUP+T_WRITE+T_RECOV cycles
        acks0 = 0; acks1 = 0;
        wr_req = 1'b1;
        for (int c = 0; c < 60; c++) begin
            br_data = 13'($urandom);
            mod_sel = legalList[$urandom_range(0, 5)];
            @(posedge clk); #2;
            if (wrAck[0] === 1'b1) acks0++;
            if (wrAck[1] === 1'b1) acks1++;
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("held acks default", 32'(acks0), 32'd6);
        chk("held acks fast", 32'(acks1), 32'd15);
        idleCycles(12);

        // Reset during WRITE, with a simultaneous request
        br_data = 13'h0ABC; mod_sel = 4'b0100; wr_req = 1'b1;
        @(posedge clk); #2;
        chk("rst ack", 32'(wrAck[0]), 32'h1);
        @(negedge clk);
        wr_req = 1'b0;
        for (int m = 2; m <= 4; m++) @(posedge clk);
        #2;
        chk("rst pre xy", 32'(xyO[0]), 32'h4);
        @(negedge clk);
        rst = 1'b1; wr_req = 1'b1; mod_sel = 4'b0010;
        @(posedge clk); #2;
        chk("rst xy", 32'(xyO[0]), 32'h0);
        chk("rst inh", 32'(inhO[0]), 32'h0);
        chk("rst busy", 32'(busyO[0]), 32'h0);
        chk("rst ack prio", 32'(wrAck[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("post rst ack", 32'(wrAck[0]), 32'h1);
        @(negedge clk);
        wr_req = 1'b0;
        idleCycles(12);

        // Randomised traffic including stray resets and illegal masks
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 59) == 0);
            wr_req  = ($urandom_range(0, 2) == 0);
            br_data = 13'($urandom);
            mod_sel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legalList[$urandom_range(0, 5)];
            @(negedge clk);
        end
        rst = 1'b0; wr_req = 1'b0;
        idleCycles(15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
